rect_painter: RTL and testbench
===============================

RECT_PAINTER -- requirements
Module: rect_painter

Interface
REQ-001 The block SHALL have parameter X_W, default 8, meaning the x coordinate width.
REQ-002 The block SHALL have parameter Y_W, default 7, meaning the y coordinate width.
REQ-003 The block SHALL have parameter COLOUR_W, default 3, meaning the pixel colour width.
REQ-004 Port clock  in  1  meaning the single clock; all logic on posedge.
REQ-005 Port reset_n  in  1  meaning a synchronous, active-low reset.
REQ-006 Port start  in  1  meaning begin a job; sampled only in IDLE.
REQ-007 Port abort  in  1  meaning terminate the current job.
REQ-008 Port mode  in  1  meaning 0 = solid fill, 1 = outline only.
REQ-009 Port fill_colour  in  COLOUR_W  meaning the colour for every pixel of the job.
REQ-010 Ports lowerXBound, upperXBound  in  X_W  meaning the inclusive x bounds.
REQ-011 Ports lowerYBound, upperYBound  in  Y_W  meaning the inclusive y bounds.
REQ-012 Port ready  in  1  meaning the downstream pixel sink accepts a write this cycle.
REQ-013 Ports x, y, colour  out  X_W, Y_W, COLOUR_W  meaning the registered pixel write.
REQ-014 Port writeEn  out  1  meaning the x/y/colour outputs are a valid write.
REQ-015 Ports busy, done  out  1 each  meaning a job is active / the block is idle; done = ~busy.

Function
REQ-016 The block SHALL implement an FSM with states IDLE and DRAW.
REQ-017 In IDLE with start=1, the block SHALL latch mode, fill_colour and all four bounds, then enter DRAW; bound or mode changes during DRAW SHALL have no effect.
REQ-018 If lowerX>upperX or lowerY>upperY at start, the block SHALL stay in IDLE, issue zero writes and keep done=1.
REQ-019 The first write SHALL appear on the clock edge after start is sampled (1-cycle latency), at (lowerX, lowerY).
REQ-020 Scan order SHALL be raster: x ascends within a row; after upperX, x returns to lowerX and y increments.
REQ-021 A write SHALL count as consumed on an edge where writeEn=1 and ready=1; while ready=0, x, y, colour and writeEn SHALL hold stable.
REQ-022 In solid mode, the block SHALL issue exactly (uX-lX+1)*(uY-lY+1) writes; with ready held at 1, that is one per cycle with no gaps.
REQ-023 In outline mode, first and last rows SHALL be written in full.
REQ-024 In outline mode, each interior row SHALL write only lowerX, then upperX (only lowerX if lX=uX), skipping interior pixels without idle cycles.
REQ-025 Coordinate stepping SHALL compare against bounds before incrementing, so that upperX=2^X_W-1 or upperY=2^Y_W-1 never wraps or loops.
REQ-026 After the last write is consumed, the block SHALL enter IDLE on that edge: writeEn=0, busy=0, done=1.
REQ-027 The colour output SHALL equal the latched fill_colour on every write.
REQ-028 When not writing, x, y and colour SHALL be 0.
REQ-029 Abort=1 in DRAW SHALL force IDLE on that edge, with writeEn=0 next cycle; any pending unaccepted write is dropped.
REQ-030 Abort SHALL take priority over ready.
REQ-031 Abort in IDLE SHALL be ignored.
REQ-032 If start and abort are both high in IDLE, abort SHALL win and no job starts.
REQ-033 Start during DRAW SHALL be ignored.

Reset
REQ-034 With reset_n=0 at a clock edge, the block SHALL enter IDLE.
REQ-035 On that reset, x=0, y=0, colour=0, writeEn=0, busy=0 and done=1.
REQ-036 On that reset, the latched job registers SHALL clear to 0.
REQ-037 Reset mid-job SHALL abandon the job with no further writes.
REQ-038 Reset SHALL take priority over start and abort.

Structure
REQ-039 Package rect_painter_pkg SHALL hold the state enum (IDLE, DRAW), the mode enum (MODE_FILL, MODE_OUTLINE) and the default width constants.
REQ-040 Next-coordinate logic SHALL live in sub-module raster_stepper: given current x/y, bounds and mode, it produces next x/y and a last-pixel flag, combinationally.
REQ-041 rect_painter SHALL own the FSM, latches and output registers.

Verification
REQ-042 Bench SHALL run solid mode, bounds x 2..4, y 1..2, colour 3'b101, ready=1 -> 6 consecutive writes (2,1)(3,1)(4,1)(2,2)(3,2)(4,2), then done=1 the next cycle.
REQ-043 Bench SHALL run outline mode, x 0..3, y 0..3 -> 12 writes; rows 1 and 2 write only x=0 and x=3.
REQ-044 Bench SHALL run solid mode, x 254..255, y 126..127, ready toggling 1,0,1,0 -> 4 writes with outputs held across ready=0 cycles, no wrap, done after (255,127).
REQ-045 Bench SHALL start with lowerX=5, upperX=4 -> zero writes and done stays 1.
REQ-046 Bench SHALL run solid 10x10, asserting abort after the 7th write -> writeEn=0 next cycle and done=1; a new start then begins at the new lower bounds.
REQ-047 Bench SHALL assert reset_n=0 mid-job, with start=1 held -> all outputs at reset values and no job runs while reset_n=0.

Source files
------------

// File: rtl/rect_painter_pkg.sv
// Shared types and default widths for the rectangle painter.
package rect_painter_pkg;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    typedef enum logic {
        MODE_FILL    = 1'b0,
        MODE_OUTLINE = 1'b1
    } mode_t;

endpackage

// File: rtl/rect_painter_if.sv
// Pixel write bus from the painter to a downstream pixel sink.
interface rect_painter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                writeEn;
    logic                ready;

    modport master (output x, y, colour, writeEn, input ready);
    modport slave  (input x, y, colour, writeEn, output ready);
endinterface

// File: rtl/rect_painter_raster_stepper.sv
// Combinational next-pixel generator: raster order, optional outline skipping.
module raster_stepper
    import rect_painter_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] lower_x,
    input  logic [X_W-1:0] upper_x,
    input  logic [Y_W-1:0] lower_y,
    input  logic [Y_W-1:0] upper_y,
    input  mode_t          mode,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           last
);

    logic interior_row;

    always_comb begin
        last         = (x == upper_x) && (y == upper_y);
        interior_row = (mode == MODE_OUTLINE) && (y != lower_y) && (y != upper_y);
        next_x       = x;
        next_y       = y;
        // Bounds are compared before any increment so a full-range bound never wraps.
        if (x == upper_x) begin
            next_x = lower_x;
            if (y != upper_y) begin
                next_y = y + Y_W'(1);
            end
        end else if (interior_row && (x == lower_x)) begin
            next_x = upper_x;
        end else begin
            next_x = x + X_W'(1);
        end
    end

endmodule

// File: rtl/rect_painter.sv
// Rectangle painter: latches a job on start and streams pixel writes under ready.
module rect_painter
    import rect_painter_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                mode,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [X_W-1:0]      lowerXBound,
    input  logic [X_W-1:0]      upperXBound,
    input  logic [Y_W-1:0]      lowerYBound,
    input  logic [Y_W-1:0]      upperYBound,
    output logic                busy,
    output logic                done,
    rect_painter_if.master      pix
);

    state_t              state;
    mode_t               mode_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [X_W-1:0]      lx_q, ux_q;
    logic [Y_W-1:0]      ly_q, uy_q;

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] c_q;
    logic                we_q;

    logic [X_W-1:0]      next_x;
    logic [Y_W-1:0]      next_y;
    logic                last;
    logic                job_ok;

    raster_stepper #(.X_W(X_W), .Y_W(Y_W)) u_stepper (
        .x       (x_q),
        .y       (y_q),
        .lower_x (lx_q),
        .upper_x (ux_q),
        .lower_y (ly_q),
        .upper_y (uy_q),
        .mode    (mode_q),
        .next_x  (next_x),
        .next_y  (next_y),
        .last    (last)
    );

    assign job_ok = (lowerXBound <= upperXBound) && (lowerYBound <= upperYBound);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_q   <= MODE_FILL;
            colour_q <= '0;
            lx_q     <= '0;
            ux_q     <= '0;
            ly_q     <= '0;
            uy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            c_q      <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort && job_ok) begin
                        state    <= DRAW;
                        mode_q   <= mode_t'(mode);
                        colour_q <= fill_colour;
                        lx_q     <= lowerXBound;
                        ux_q     <= upperXBound;
                        ly_q     <= lowerYBound;
                        uy_q     <= upperYBound;
                        x_q      <= lowerXBound;
                        y_q      <= lowerYBound;
                        c_q      <= fill_colour;
                        we_q     <= 1'b1;
                    end
                end
                DRAW: begin
                    // Abort drops the pending write regardless of ready.
                    if (abort || (pix.ready && last)) begin
                        state <= IDLE;
                        x_q   <= '0;
                        y_q   <= '0;
                        c_q   <= '0;
                        we_q  <= 1'b0;
                    end else if (pix.ready) begin
                        x_q <= next_x;
                        y_q <= next_y;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix.x       = x_q;
    assign pix.y       = y_q;
    assign pix.colour  = c_q;
    assign pix.writeEn = we_q;
    assign busy        = (state == DRAW);
    assign done        = ~busy;

endmodule

// File: tb/tb_rect_painter.sv
// Scoreboard bench for rect_painter: expected pixels queued at launch, compared on consumption.
module tb_rect_painter;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int PW       = X_W + Y_W + COLOUR_W;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                mode = 1'b0;
    logic [COLOUR_W-1:0] fill_colour = '0;
    logic [X_W-1:0]      lowerXBound = '0;
    logic [X_W-1:0]      upperXBound = '0;
    logic [Y_W-1:0]      lowerYBound = '0;
    logic [Y_W-1:0]      upperYBound = '0;
    logic                busy, done;

    rect_painter_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

    rect_painter #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .fill_colour (fill_colour),
        .lowerXBound (lowerXBound),
        .upperXBound (upperXBound),
        .lowerYBound (lowerYBound),
        .upperYBound (upperYBound),
        .busy        (busy),
        .done        (done),
        .pix         (bus)
    );

    always #5 clock = ~clock;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] obs_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            hold_err;
    bit            timed_out;

    task automatic model(input int lx, input int ux, input int ly, input int uy,
                         input bit md, input logic [COLOUR_W-1:0] c);
        for (int yy = ly; yy <= uy; yy++)
            for (int xx = lx; xx <= ux; xx++)
                if (!md || yy == ly || yy == uy || xx == lx || xx == ux)
                    exp_q.push_back({X_W'(xx), Y_W'(yy), c});
    endtask

    task automatic launch(input int lx, input int ux, input int ly, input int uy,
                          input bit md, input logic [COLOUR_W-1:0] c);
        lowerXBound = X_W'(lx);
        upperXBound = X_W'(ux);
        lowerYBound = Y_W'(ly);
        upperYBound = Y_W'(uy);
        mode        = md;
        fill_colour = c;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
    endtask

    // Records consumed writes and counts output changes while ready is low.
    task automatic collect(input int budget, input bit toggle, output int wcycles);
        logic [PW-1:0] held;
        bit            pending;
        wcycles   = 0;
        hold_err  = 0;
        timed_out = 1'b1;
        pending   = 1'b0;
        held      = '0;
        for (int i = 0; i < budget; i++) begin
            if (pending) begin
                if (bus.writeEn !== 1'b1 || {bus.x, bus.y, bus.colour} !== held) hold_err++;
                pending = 1'b0;
            end
            if (bus.writeEn !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            wcycles++;
            bus.ready = toggle ? (i % 2 == 0) : 1'b1;
            if (bus.ready) begin
                obs_q.push_back({bus.x, bus.y, bus.colour});
            end else begin
                held    = {bus.x, bus.y, bus.colour};
                pending = 1'b1;
            end
            @(negedge clock);
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.ready = 1'b1;
        reset_n = 1'b0;
        lowerXBound = 8'd1; upperXBound = 8'd3; lowerYBound = 7'd1; upperYBound = 7'd3;
        start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.x, bus.y, bus.colour, bus.writeEn, busy, done} !== {{PW{1'b0}}, 3'b001})
            $display("FAIL reset_state got x=%0d y=%0d c=%0d we=%b busy=%b done=%b want 0 0 0 0 0 1",
                     bus.x, bus.y, bus.colour, bus.writeEn, busy, done);
        else n_pass++;
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.writeEn !== 1'b0) $display("FAIL post_reset_idle got we=%b want 0", bus.writeEn);
        else n_pass++;
    endtask

    task automatic test_solid();
        int wc;
        launch(2, 4, 1, 2, 1'b0, 3'b101);
        model(2, 4, 1, 2, 1'b0, 3'b101);
        // Inputs changed mid-job must be ignored.
        lowerXBound = 8'd0; upperXBound = 8'd200; mode = 1'b1; fill_colour = 3'b010;
        n_checks++;
        if (bus.writeEn !== 1'b1 || bus.x !== 8'd2 || bus.y !== 7'd1)
            $display("FAIL solid_first_latency got we=%b x=%0d y=%0d want 1 2 1", bus.writeEn, bus.x, bus.y);
        else n_pass++;
        collect(20, 1'b0, wc);
        n_checks++;
        if (wc !== 6 || timed_out) $display("FAIL solid_cycles got=%0d timeout=%b want=6", wc, timed_out);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL solid_done got done=%b busy=%b want 1 0", done, busy);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL solid_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [PW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL solid_pixel got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_outline();
        int wc;
        launch(0, 3, 0, 3, 1'b1, 3'b010);
        model(0, 3, 0, 3, 1'b1, 3'b010);
        collect(40, 1'b0, wc);
        n_checks++;
        if (wc !== 12 || timed_out) $display("FAIL outline_cycles got=%0d timeout=%b want=12", wc, timed_out);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL outline_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [PW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL outline_pixel got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_boundary();
        int wc;
        launch(254, 255, 126, 127, 1'b0, 3'b111);
        model(254, 255, 126, 127, 1'b0, 3'b111);
        collect(30, 1'b1, wc);
        n_checks++;
        if (wc !== 7 || timed_out) $display("FAIL boundary_cycles got=%0d timeout=%b want=7", wc, timed_out);
        else n_pass++;
        n_checks++;
        if (hold_err !== 0) $display("FAIL boundary_hold got=%0d changes want=0", hold_err);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1) $display("FAIL boundary_done got=%b want=1", done);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL boundary_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [PW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL boundary_pixel got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_empty();
        launch(5, 4, 0, 3, 1'b0, 3'b001);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.writeEn !== 1'b0 || done !== 1'b1)
                $display("FAIL empty_x got we=%b done=%b want 0 1", bus.writeEn, done);
            else n_pass++;
            @(negedge clock);
        end
        launch(0, 3, 6, 2, 1'b0, 3'b001);
        n_checks++;
        if (bus.writeEn !== 1'b0 || done !== 1'b1)
            $display("FAIL empty_y got we=%b done=%b want 0 1", bus.writeEn, done);
        else n_pass++;
    endtask

    task automatic test_start_abort();
        lowerXBound = 8'd0; upperXBound = 8'd3; lowerYBound = 7'd0; upperYBound = 7'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.writeEn !== 1'b0 || busy !== 1'b0)
            $display("FAIL start_abort_idle got we=%b busy=%b want 0 0", bus.writeEn, busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        int cnt;
        int wc;
        bit stuck;
        cnt = 0;
        stuck = 1'b1;
        bus.ready = 1'b1;
        launch(0, 9, 0, 9, 1'b0, 3'b011);
        model(0, 9, 0, 9, 1'b0, 3'b011);
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        for (int i = 0; i < 20; i++) begin
            if (cnt == 7) begin
                stuck = 1'b0;
                break;
            end
            if (bus.writeEn === 1'b1) begin
                obs_q.push_back({bus.x, bus.y, bus.colour});
                cnt++;
            end
            @(negedge clock);
        end
        n_checks++;
        if (stuck) $display("FAIL abort_reach7 got=%0d writes want=7", cnt);
        else n_pass++;
        abort = 1'b1;
        bus.ready = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        bus.ready = 1'b1;
        n_checks++;
        if (bus.writeEn !== 1'b0 || done !== 1'b1 || bus.x !== 8'd0)
            $display("FAIL abort_idle got we=%b done=%b x=%0d want 0 1 0", bus.writeEn, done, bus.x);
        else n_pass++;
        launch(20, 21, 30, 30, 1'b0, 3'b110);
        model(20, 21, 30, 30, 1'b0, 3'b110);
        collect(10, 1'b0, wc);
        n_checks++;
        if (wc !== 2 || timed_out) $display("FAIL abort_restart_cycles got=%0d want=2", wc);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL abort_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [PW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL abort_pixel got=%h want=%h", o, e);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midjob();
        launch(0, 9, 0, 9, 1'b0, 3'b100);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.x, bus.y, bus.colour, bus.writeEn, busy, done} !== {{PW{1'b0}}, 3'b001})
                $display("FAIL reset_midjob got x=%0d y=%0d c=%0d we=%b busy=%b done=%b want 0 0 0 0 0 1",
                         bus.x, bus.y, bus.colour, bus.writeEn, busy, done);
            else n_pass++;
        end
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.writeEn !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release got we=%b busy=%b want 0 0", bus.writeEn, busy);
        else n_pass++;
    endtask

    initial begin
        bus.ready = 1'b1;
        test_reset();
        test_solid();
        test_outline();
        test_boundary();
        test_empty();
        test_start_abort();
        test_abort();
        test_reset_midjob();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
